// File: rtl/clk_period_meter.sv
// Period / high-time meter for a slow square wave sampled by clkIn.
// Reports rise-to-rise period, rise-to-fall high time, a lock flag and a sticky timeout.
module clk_period_meter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1000000,
    parameter int TOL     = 1
) (
    input  logic             clkIn,
    input  logic             reset,
    input  logic             sigIn,
    input  logic             enable,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] highTime,
    output logic             measValid,
    output logic             timeout,
    output logic             locked
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2
    } state_t;

    state_t stateReg, stateNext;

    // [0] first sync stage, [1] synchronized level, [2] edge-history flop
    logic [2:0]       syncReg;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] hiCapture;
    logic [WIDTH-1:0] prevPeriod;
    logic             prevValid;

    logic             rise;
    logic             fall;
    logic             atTimeout;
    logic             withinTol;
    logic [WIDTH-1:0] cntInc;
    logic [WIDTH-1:0] periodDiff;

    logic             countEn;
    logic             doMeas;
    logic             doFall;
    logic             doTimeout;
    logic             clearLock;

    assign rise       = syncReg[1] & ~syncReg[2];
    assign fall       = ~syncReg[1] & syncReg[2];
    assign atTimeout  = (cnt == WIDTH'(TIMEOUT));
    assign cntInc     = (cnt == {WIDTH{1'b1}}) ? cnt : cnt + WIDTH'(1);
    assign periodDiff = (cnt >= prevPeriod) ? (cnt - prevPeriod) : (prevPeriod - cnt);
    assign withinTol  = prevValid && (periodDiff <= WIDTH'(TOL));

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            syncReg <= 3'b000;
        end else begin
            syncReg <= {syncReg[1:0], sigIn};
        end
    end

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // A dropped enable overrides everything, including an edge seen that cycle.
    always_comb begin
        stateNext = stateReg;
        countEn   = 1'b0;
        doMeas    = 1'b0;
        doFall    = 1'b0;
        doTimeout = 1'b0;
        clearLock = 1'b0;
        if (!enable) begin
            stateNext = IDLE;
            clearLock = 1'b1;
        end else begin
            case (stateReg)
                IDLE: begin
                    stateNext = WAIT_RISE;
                    clearLock = 1'b1;
                end
                WAIT_RISE: begin
                    countEn = 1'b1;
                    if (rise) begin
                        stateNext = MEASURE;
                    end else if (atTimeout) begin
                        doTimeout = 1'b1;
                    end
                end
                MEASURE: begin
                    countEn = 1'b1;
                    doFall  = fall;
                    if (rise) begin
                        doMeas = 1'b1;
                    end else if (atTimeout) begin
                        doTimeout = 1'b1;
                        stateNext = WAIT_RISE;
                    end
                end
                default: begin
                    stateNext = IDLE;
                    clearLock = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            hiCapture  <= '0;
            prevPeriod <= '0;
            prevValid  <= 1'b0;
            period     <= '0;
            highTime   <= '0;
            measValid  <= 1'b0;
            timeout    <= 1'b0;
            locked     <= 1'b0;
        end else begin
            measValid <= doMeas;
            if (countEn) begin
                cnt <= rise ? WIDTH'(1) : cntInc;
            end
            if (doFall) begin
                hiCapture <= cnt;
            end
            if (doMeas) begin
                period     <= cnt;
                highTime   <= hiCapture;
                locked     <= withinTol;
                prevPeriod <= cnt;
                prevValid  <= 1'b1;
                timeout    <= 1'b0;
            end
            if (doTimeout) begin
                timeout   <= 1'b1;
                locked    <= 1'b0;
                prevValid <= 1'b0;
            end
            if (clearLock) begin
                locked    <= 1'b0;
                prevValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomized scoreboard bench: two meters (TIMEOUT 50 and 1000) watch the same waveform
// and are compared against a timestamp-style reference model of the measurement rules.
module tb_clk_period_meter;

    localparam int  W    = 32;
    localparam int  TOL  = 1;
    localparam longint MAXC = 64'hFFFF_FFFF;

    logic clkIn  = 1'b0;
    logic reset  = 1'b1;
    logic sigIn  = 1'b0;
    logic enable = 1'b0;

    logic [W-1:0] period   [2];
    logic [W-1:0] highTime [2];
    logic         measValid[2];
    logic         timeout  [2];
    logic         locked   [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            clk_period_meter #(
                .WIDTH  (W),
                .TIMEOUT(gi == 0 ? 50 : 1000),
                .TOL    (TOL)
            ) dut (
                .clkIn    (clkIn),
                .reset    (reset),
                .sigIn    (sigIn),
                .enable   (enable),
                .period   (period[gi]),
                .highTime (highTime[gi]),
                .measValid(measValid[gi]),
                .timeout  (timeout[gi]),
                .locked   (locked[gi])
            );
        end
    endgenerate

    always #5 clkIn = ~clkIn;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input int idx, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s dut%0d actual=%0d required=%0d t=%0t", name, idx, act, exp, $time);
    endtask

    typedef struct {
        longint p;
        longint h;
        bit     lk;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model: mode 0 = stopped, 1 = armed (waiting for first edge), 2 = measuring.
    int     mMode[2];
    longint mCnt[2];
    longint mHi[2];
    longint mPrev[2];
    bit     mPrevOk[2];
    bit     mTo[2];
    bit     mLk[2];
    bit [2:0] seen;

    function automatic longint toOf(input int i);
        return (i == 0) ? 64'd50 : 64'd1000;
    endfunction

    always @(posedge clkIn or posedge reset) begin
        if (reset) begin
            seen = 3'b000;
            for (int i = 0; i < 2; i++) begin
                mMode[i] = 0; mCnt[i] = 0; mHi[i] = 0; mPrev[i] = 0;
                mPrevOk[i] = 0; mTo[i] = 0; mLk[i] = 0;
            end
            q0.delete();
            q1.delete();
        end else begin
            // edges become visible three samples after they occur on sigIn
            bit r, f;
            r = seen[1] & ~seen[2];
            f = ~seen[1] & seen[2];
            for (int i = 0; i < 2; i++) begin
                if (!enable) begin
                    mMode[i] = 0; mLk[i] = 0; mPrevOk[i] = 0;
                end else if (mMode[i] == 0) begin
                    mMode[i] = 1;
                end else if (r) begin
                    if (mMode[i] == 2) begin
                        exp_t e;
                        longint d;
                        d = (mCnt[i] > mPrev[i]) ? mCnt[i] - mPrev[i] : mPrev[i] - mCnt[i];
                        e.p = mCnt[i]; e.h = mHi[i]; e.lk = mPrevOk[i] && (d <= TOL);
                        if (i == 0) q0.push_back(e); else q1.push_back(e);
                        mLk[i] = e.lk; mPrev[i] = mCnt[i]; mPrevOk[i] = 1; mTo[i] = 0;
                    end
                    mMode[i] = 2;
                    mCnt[i]  = 1;
                end else begin
                    if (mMode[i] == 2 && f) mHi[i] = mCnt[i];
                    if (mCnt[i] == toOf(i)) begin
                        mTo[i] = 1; mLk[i] = 0; mPrevOk[i] = 0; mMode[i] = 1;
                    end
                    if (mCnt[i] < MAXC) mCnt[i] = mCnt[i] + 1;
                end
            end
            seen = {seen[1:0], sigIn};
        end
    end

    // Monitor: pop one expectation per measValid pulse; flags compared every cycle.
    always @(negedge clkIn) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                int qs;
                qs = (i == 0) ? q0.size() : q1.size();
                if (measValid[i]) begin
                    if (qs == 0) begin
                        check("unexpected_measValid", i, 1, 0);
                    end else begin
                        exp_t e;
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        check("period", i, longint'(period[i]), e.p);
                        check("highTime", i, longint'(highTime[i]), e.h);
                        check("locked_at_meas", i, longint'(locked[i]), longint'(e.lk));
                        $display("meas dut%0d period=%0d highTime=%0d locked=%0d", i, period[i], highTime[i], locked[i]);
                    end
                end else if (qs != 0) begin
                    check("missing_measValid", i, 0, 1);
                    if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                end
                check("timeout_flag", i, longint'(timeout[i]), longint'(mTo[i]));
                check("locked_flag", i, longint'(locked[i]), longint'(mLk[i]));
            end
        end
    end

    task automatic wave(input int p, input int h, input int n);
        repeat (n) begin
            for (int c = 0; c < p; c++) begin
                @(negedge clkIn);
                sigIn = (c >= p - h);
            end
        end
    endtask

    task automatic divider(input int n, input int reps);
        wave(n + 1, n + 1 - n / 2, reps);
    endtask

    task automatic checkZero(input string name);
        for (int i = 0; i < 2; i++) begin
            check({name, "_period"}, i, longint'(period[i]), 0);
            check({name, "_highTime"}, i, longint'(highTime[i]), 0);
            check({name, "_measValid"}, i, longint'(measValid[i]), 0);
            check({name, "_timeout"}, i, longint'(timeout[i]), 0);
            check({name, "_locked"}, i, longint'(locked[i]), 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clkIn);
        checkZero("reset");
        reset = 1'b0;
        @(negedge clkIn);
        enable = 1'b1;

        divider(100, 6);
        check("div100_period", 1, longint'(period[1]), 101);
        check("div100_highTime", 1, longint'(highTime[1]), 51);
        check("div100_locked", 1, longint'(locked[1]), 1);

        divider(10, 8);
        check("div10_period", 0, longint'(period[0]), 11);
        check("div10_highTime", 0, longint'(highTime[0]), 6);
        divider(12, 8);
        check("div12_period", 0, longint'(period[0]), 13);
        check("div12_highTime", 0, longint'(highTime[0]), 7);
        check("div12_locked", 0, longint'(locked[0]), 1);

        repeat (60) begin
            @(negedge clkIn);
            sigIn = 1'b0;
        end
        check("hold_timeout", 0, longint'(timeout[0]), 1);
        check("hold_locked", 0, longint'(locked[0]), 0);
        check("hold_period", 0, longint'(period[0]), 13);
        wave(13, 7, 5);
        check("resume_timeout", 0, longint'(timeout[0]), 0);
        check("resume_locked", 0, longint'(locked[0]), 1);

        repeat (4) begin
            wave(20, 10, 1);
            wave(21, 10, 1);
        end
        check("tol_locked", 0, longint'(locked[0]), 1);
        wave(20, 10, 2);
        wave(22, 11, 1);
        wave(20, 10, 2);

        wave(30, 15, 2);
        repeat (15) begin
            @(negedge clkIn);
            sigIn = 1'b0;
        end
        repeat (5) begin
            @(negedge clkIn);
            sigIn = 1'b1;
        end
        @(posedge clkIn);
        #2 reset = 1'b1;
        #1 checkZero("async_reset");
        @(posedge clkIn);
        #2 reset = 1'b0;
        wave(30, 15, 3);

        wave(25, 12, 3);
        repeat (10) begin
            @(negedge clkIn);
            sigIn = 1'b0;
        end
        @(negedge clkIn);
        enable = 1'b0;
        wave(8, 4, 3);
        check("disable_locked", 0, longint'(locked[0]), 0);
        enable = 1'b1;
        wave(25, 12, 4);
        check("reenable_period", 0, longint'(period[0]), 25);
        check("reenable_locked", 0, longint'(locked[0]), 1);

        for (int k = 0; k < 30; k++) begin
            int p, h;
            p = $urandom_range(60, 4);
            h = $urandom_range(p - 1, 1);
            wave(p, h, $urandom_range(4, 1));
            if ($urandom_range(7, 0) == 0) begin
                @(negedge clkIn);
                enable = 1'b0;
                repeat ($urandom_range(20, 1)) @(negedge clkIn);
                enable = 1'b1;
            end
        end

        repeat (10) @(negedge clkIn);
        check("queue0_drained", 0, longint'(q0.size()), 0);
        check("queue1_drained", 1, longint'(q1.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Measures a slow clock or square wave, such as the output of the team's clock divider, against the fast system clock.
- Reports period and high time in system-clock cycles, plus a lock indication once two consecutive periods agree.
- Used on-board to verify divider factors and to monitor externally supplied slow clocks.
- Acts as the decoder side of the divider: it recovers the divide ratio and duty from the divided waveform.

Parameters:
- WIDTH, 32, width of the cycle counter and the measurement outputs.
- TIMEOUT, 1000000, number of clkIn cycles without a detected rising edge before the timeout flag is raised; legal range 4 .. 2^WIDTH-1.
- TOL, 1, maximum absolute difference between consecutive periods that still counts as "equal" for lock.

Ports:
- clkIn  input  1  system clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- sigIn  input  1  measured signal; asynchronous to clkIn.
- enable  input  1  measurement enable; low forces IDLE.
- period  output  WIDTH  last measured period in clkIn cycles (rise to rise).
- highTime  output  WIDTH  last measured high time in clkIn cycles (rise to fall).
- measValid  output  1  one-cycle pulse when period/highTime are updated.
- timeout  output  1  sticky flag: no rising edge seen within TIMEOUT cycles.
- locked  output  1  two consecutive periods within TOL of each other.

Behaviour:
- Interface: one clock, clkIn; reset is asynchronous and active-high.
- Reset (asserted at any time, including mid-measurement):
  - state=IDLE; counter=0.
  - period=0, highTime=0, measValid=0, timeout=0, locked=0.
  - Synchronizer flops and edge-history flop =0.
- Input conditioning:
  - sigIn passes through a 2-flop synchronizer, then a history flop.
  - rise = sync & ~hist; fall = ~sync & hist.
  - Detection latency is 3 clkIn cycles. It is identical for rise and fall, so measured intervals are unbiased.
- Counter:
  - On a rise-detect cycle, cnt <= 1.
  - Otherwise cnt <= cnt+1, saturating at all-ones. It never wraps.
- IDLE:
  - All counting stopped.
  - Outputs period/highTime hold their last values; locked <= 0.
  - Goes to WAIT_RISE when enable=1.
- WAIT_RISE:
  - Counter runs from the value it holds when entering WAIT_RISE and is used only for timeout; fall events are ignored.
  - On rise: cnt <= 1, go to MEASURE. measValid is not pulsed because there is no prior edge.
- MEASURE:
  - On fall: hiCapture <= cnt (internal).
  - On rise:
    - period <= cnt; highTime <= hiCapture; measValid=1 for exactly that cycle; cnt <= 1.
    - locked <= 1 if a previous period exists since entering MEASURE and |cnt - prevPeriod| <= TOL; otherwise locked <= 0.
    - prevPeriod <= cnt.
    - timeout <= 0.
- Timeout, in WAIT_RISE or MEASURE:
  - If cnt == TIMEOUT and no rise occurs that cycle: timeout <= 1, locked <= 0, prevPeriod is invalidated, go to WAIT_RISE.
  - A rise on the same cycle wins: it is treated as a normal rise and timeout is not set.
- enable dropping in any state:
  - Next cycle the state is IDLE; an edge detected in that same cycle is discarded.
  - Outputs hold; locked and prevPeriod are cleared.
  - The timeout flag holds until the next valid measurement or reset.
- Widths: cnt, prevPeriod and hiCapture are WIDTH bits. The TOL comparison uses unsigned absolute difference, without overflow.
- A divider of factor N (counter 0..N, output high when counter >= N/2) yields period = N+1 and highTime = N+1-N/2 (integer division).

Test Plan:
- Reset, then enable=1 and drive sigIn from a divider model with factor 100 -> first measValid on the second detected rise; period=101, highTime=51; locked=1 from the third rise onward.
- Divider factor 10 -> period=11, highTime=6. Switch to factor 12 mid-run -> one measValid with locked=0, then period=13, highTime=7 with locked=1 again.
- TIMEOUT=50, hold sigIn low after lock -> timeout=1 and locked=0 exactly 50 cycles after the last rise-detect; period/highTime unchanged. Resume toggling -> timeout clears at the next measValid.
- Periods alternating 20/21/20 with TOL=1 -> locked stays 1. Periods 20/22 -> locked=0 at the 22 measurement.
- Assert reset asynchronously mid-high-phase -> all outputs are 0 immediately, before the next clkIn edge. After release, the first measValid requires two fresh rises.
- enable=0 mid-measurement -> no measValid and locked=0. Re-enable -> measurement restarts from WAIT_RISE; the first valid result is the correct full period, not a partial one.
